// File: rtl/xnor_pkg.sv
// Shared constants and helpers for the registered XNOR compare unit.
package xnor_pkg;

  // Widest operand the unit is meant to be built with.
  localparam int unsigned MAX_WIDTH = 64;

  // ceil(log2(n)), but never below 1 so a count port always has at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/xnor_gate_popcount.sv
// Combinational population count, built as a balanced pairwise adder tree.
module xnor_gate_popcount
  import xnor_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = clog2_min1(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CNT_W-1:0] count_o
);

  // Leaves padded up to a power of two; padding bits are zero and add nothing.
  localparam int unsigned Levels = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int unsigned Leaves = 1 << Levels;

  logic [Leaves-1:0] vec_pad;
  assign vec_pad = Leaves'(vec_i);

  // Each pass halves the number of partial sums; the root lands in slot 0.
  // Partial sums never exceed WIDTH, so CNT_W bits are enough at every level.
  always_comb begin
    logic [CNT_W-1:0] lvl [Leaves];
    for (int i = 0; i < Leaves; i++) begin
      lvl[i] = CNT_W'(vec_pad[i]);
    end
    for (int s = Leaves / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        lvl[i] = lvl[2*i] + lvl[2*i+1];
      end
    end
    count_o = lvl[0];
  end

endmodule

// File: rtl/xnor_gate.sv
// Registered bitwise XNOR with whole-word equality flag and matching-bit count.
module xnor_gate
  import xnor_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = clog2_min1(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             eq,
  output logic [CNT_W-1:0] match_count,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("xnor_gate: WIDTH out of range");
  end

  logic [WIDTH-1:0] xnor_vec;
  logic [CNT_W-1:0] xnor_cnt;

  logic [WIDTH-1:0] y_d, y_q;
  logic             eq_d, eq_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             valid_d, valid_q;

  assign xnor_vec = ~(a ^ b);

  xnor_gate_popcount #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_popcount (
    .vec_i   (xnor_vec),
    .count_o (xnor_cnt)
  );

  // Capture a fresh result on valid input; otherwise hold results and drop valid.
  always_comb begin
    y_d     = y_q;
    eq_d    = eq_q;
    cnt_d   = cnt_q;
    valid_d = in_valid;
    if (in_valid) begin
      y_d   = xnor_vec;
      eq_d  = &xnor_vec;
      cnt_d = xnor_cnt;
    end
  end

  // Output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      eq_q    <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      eq_q    <= eq_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign y           = y_q;
  assign eq          = eq_q;
  assign match_count = cnt_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_xnor_gate.sv
// Self-checking bench for xnor_gate at WIDTH = 1, 8 and 13.
module tb_xnor_gate;

  logic clk;
  logic rst_n;

  logic        a1, b1, v1, y1, eq1, vo1;
  logic [0:0]  c1;
  logic [7:0]  a8, b8, y8;
  logic        v8, eq8, vo8;
  logic [3:0]  c8;
  logic [12:0] a13, b13, y13;
  logic        v13, eq13, vo13;
  logic [3:0]  c13;

  int n_total;
  int n_bad;

  xnor_gate #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .y(y1), .eq(eq1), .match_count(c1), .out_valid(vo1)
  );

  xnor_gate #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
    .y(y8), .eq(eq8), .match_count(c8), .out_valid(vo8)
  );

  xnor_gate #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .a(a13), .b(b13), .in_valid(v13),
    .y(y13), .eq(eq13), .match_count(c13), .out_valid(vo13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs were set at a falling edge, results observed at the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: bit i is 1 exactly when the operands agree at position i.
  function automatic logic [63:0] ref_y(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = (a[i] == b[i]);
    return r;
  endfunction

  function automatic int ref_cnt(input logic [63:0] a, input logic [63:0] b, input int w);
    int c;
    c = 0;
    for (int i = 0; i < w; i++) if (a[i] == b[i]) c++;
    return c;
  endfunction

  task automatic check8(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    int c;
    c = ref_cnt(64'(ea), 64'(eb), 8);
    check_val({tag, "_y"},   64'(y8),  ref_y(64'(ea), 64'(eb), 8));
    check_val({tag, "_cnt"}, 64'(c8),  64'(c));
    check_val({tag, "_eq"},  64'(eq8), 64'(c == 8));
    check_val({tag, "_ov"},  64'(vo8), 64'(1));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tt [4];
    logic [7:0] eqv [3][2];
    logic [7:0] eqy [3];
    int eqc [3];
    logic [7:0] msa [4];
    logic [7:0] msb [4];
    logic [63:0] exp_y;
    int exp_c;
    logic exp_eq, exp_v;

    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    a1 = 0; b1 = 0; v1 = 0;
    a8 = '0; b8 = '0; v8 = 0;
    a13 = '0; b13 = '0; v13 = 0;

    // Reset state.
    @(negedge clk);
    check_val("rst_y8",   64'(y8),   64'(0));
    check_val("rst_ov8",  64'(vo8),  64'(0));
    check_val("rst_y13",  64'(y13),  64'(0));
    check_val("rst_ov13", 64'(vo13), 64'(0));

    // Held reset with active, matching inputs must keep everything cleared.
    v1 = 1; a1 = 1; b1 = 1;
    v8 = 1; a8 = 8'hFF; b8 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("hold_y1",   64'(y1),  64'(0));
      check_val("hold_eq1",  64'(eq1), 64'(0));
      check_val("hold_cnt1", 64'(c1),  64'(0));
      check_val("hold_ov1",  64'(vo1), 64'(0));
      check_val("hold_y8",   64'(y8),  64'(0));
      check_val("hold_cnt8", 64'(c8),  64'(0));
    end
    rst_n = 1'b1;
    step();
    check_val("rel_y1",   64'(y1),  64'(1));
    check_val("rel_eq1",  64'(eq1), 64'(1));
    check_val("rel_cnt1", 64'(c1),  64'(1));
    check_val("rel_ov1",  64'(vo1), 64'(1));
    check_val("rel_y8",   64'(y8),  64'(8'hFF));
    check_val("rel_cnt8", 64'(c8),  64'(8));
    v8 = 0;

    // WIDTH=1 truth table: 00, 01, 10, 11.
    tt = '{1, 0, 0, 1};
    for (int k = 0; k < 4; k++) begin
      a1 = k[1];
      b1 = k[0];
      v1 = 1;
      step();
      check_val("tt_y",   64'(y1),  64'(tt[k]));
      check_val("tt_eq",  64'(eq1), 64'(tt[k]));
      check_val("tt_cnt", 64'(c1),  64'(tt[k]));
      check_val("tt_ov",  64'(vo1), 64'(1));
    end
    v1 = 0;

    // WIDTH=8 fixed vectors with hand-derived results.
    eqv = '{'{8'hA5, 8'hA5}, '{8'hA5, 8'h5A}, '{8'hF0, 8'hFF}};
    eqy = '{8'hFF, 8'h00, 8'hF0};
    eqc = '{8, 0, 4};
    for (int k = 0; k < 3; k++) begin
      a8 = eqv[k][0];
      b8 = eqv[k][1];
      v8 = 1;
      step();
      check_val("w8_y",   64'(y8),  64'(eqy[k]));
      check_val("w8_cnt", 64'(c8),  64'(eqc[k]));
      check_val("w8_eq",  64'(eq8), 64'(eqc[k] == 8));
      check_val("w8_ov",  64'(vo8), 64'(1));
    end

    // Idle cycles hold the last result with out_valid low.
    v8 = 0;
    a8 = 8'h00;
    b8 = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      step();
      check_val("idle_ov",  64'(vo8), 64'(0));
      check_val("idle_y",   64'(y8),  64'(8'hF0));
      check_val("idle_eq",  64'(eq8), 64'(0));
      check_val("idle_cnt", 64'(c8),  64'(4));
    end

    // Asynchronous reset pulse mid-stream.
    msa = '{8'h3C, 8'h0F, 8'h81, 8'hAA};
    msb = '{8'h3C, 8'h00, 8'h7E, 8'hAB};
    for (int k = 0; k < 4; k++) begin
      a8 = msa[k];
      b8 = msb[k];
      v8 = 1;
      if (k == 2) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("async_y",   64'(y8),  64'(0));
        check_val("async_eq",  64'(eq8), 64'(0));
        check_val("async_cnt", 64'(c8),  64'(0));
        check_val("async_ov",  64'(vo8), 64'(0));
        #1 rst_n = 1'b1;
      end
      step();
      check8("ms", msa[k], msb[k]);
    end
    v8 = 0;

    // Randomized WIDTH=13 against the reference model.
    exp_y  = '0;
    exp_c  = 0;
    exp_eq = 0;
    exp_v  = 0;
    for (int n = 0; n < 1000; n++) begin
      a13 = 13'($urandom());
      b13 = 13'($urandom());
      if ($urandom_range(0, 7) == 0) b13 = a13;
      v13 = 1'($urandom_range(0, 1));
      if (v13) begin
        exp_y  = ref_y(64'(a13), 64'(b13), 13);
        exp_c  = ref_cnt(64'(a13), 64'(b13), 13);
        exp_eq = (exp_c == 13);
      end
      exp_v = v13;
      step();
      check_val("r13_y",   64'(y13),  exp_y);
      check_val("r13_cnt", 64'(c13),  64'(exp_c));
      check_val("r13_eq",  64'(eq13), 64'(exp_eq));
      check_val("r13_ov",  64'(vo13), 64'(exp_v));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/xnor_gate.md
Name: xnor_gate

Overview:
- Registered bitwise XNOR (bit-equality) unit: y[i] = ~(a[i] ^ b[i]), with one cycle of latency.
- Also produces a whole-word equality flag and a count of matching bits.
- Used as a leaf compare primitive in datapaths; WIDTH=1 is plain 2-input XNOR with a registered output.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1) (minimum 1), width of match_count; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands are sampled on this cycle.
- y  output  WIDTH  registered bitwise XNOR of a and b.
- eq  output  1  registered; 1 when a == b (all bits of y set).
- match_count  output  CNT_W  registered; number of bit positions where a[i] == b[i].
- out_valid  output  1  registered; y/eq/match_count updated by the previous cycle's in_valid.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - y = 0, eq = 0, match_count = 0, out_valid = 0.
  - Outputs stay at these values until the first valid sample after rst_n deasserts.
- Sampling: on a rising clk edge with in_valid = 1:
  - y <= ~(a ^ b).
  - eq <= &(~(a ^ b)).
  - match_count <= popcount(~(a ^ b)).
  - out_valid <= 1.
- in_valid = 0 at the edge: out_valid <= 0; y, eq and match_count hold their last values.
- Latency is exactly 1 cycle from the sampled edge to the outputs.
- No backpressure. Back-to-back in_valid gives one result per cycle.
- All three results are computed from the same sample and are mutually consistent on every cycle:
  - eq == (match_count == WIDTH).
  - match_count == popcount(y).
- Single-bit truth table for each position:
  - 00 -> 1
  - 01 -> 0
  - 10 -> 0
  - 11 -> 1
- X or Z on an input gives no defined result. The bench drives known values only.
- Reset asserted mid-stream clears the outputs at once. A sample coincident with the reset release edge is ignored.
- Widths:
  - match_count is zero-extended. Its maximum value, WIDTH, always fits in CNT_W.
  - For WIDTH = 1, match_count == y and eq == y.
- Combinational path: a/b through XNOR to the registers only. No input-to-output combinational path.

Decomposition:
- Shared package xnor_pkg:
  - function clog2_min1(n), used to derive CNT_W.
  - localparam MAX_WIDTH = 64.
- One natural sub-module, popcount, with parameters WIDTH and CNT_W. It is a combinational adder tree over the XNOR vector. xnor_gate instantiates it before the output registers.

Test Plan:
- WIDTH=1 truth table. Drive (a,b) = 00, 01, 10, 11, each with in_valid=1, each held for one cycle. Required y one cycle later: 1, 0, 0, 1. eq must equal y. match_count: 1, 0, 0, 1. out_valid=1.
- Reset. Hold rst_n=0 for 3 cycles with in_valid=1, a=b=1. Required: y=0, eq=0, match_count=0, out_valid=0 throughout. First valid result appears one cycle after the first edge following release.
- WIDTH=8 equality. a=8'hA5, b=8'hA5: y=8'hFF, eq=1, match_count=8. Then a=8'hA5, b=8'h5A: y=8'h00, eq=0, match_count=0.
- WIDTH=8 partial match. a=8'hF0, b=8'hFF: y=8'hF0, eq=0, match_count=4. Then deassert in_valid for 2 cycles: out_valid=0 and y/eq/match_count held at 8'hF0/0/4.
- Async reset mid-stream. Stream 4 back-to-back vectors; pulse rst_n low between clock edges after the second vector. Required: outputs go to 0 immediately, not at the next edge. The remaining vectors produce correct results only after a re-sample.
- Randomized WIDTH=13. 1000 random a/b with random in_valid. Required each cycle: y == ~(a^b) from the prior valid sample, match_count == popcount(y), eq == (match_count == 13).
